// File: rtl/uart_tx_fifo_if.sv
// Slave-port bundle between the interconnect and uart_tx_fifo.
interface uart_tx_fifo_if;
  logic        req;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with TX FIFO, run-time baud divisor, parity/stop options
// and a pollable status register, behind a single-cycle bus slave port.
module uart_tx_fifo #(
  parameter int CLK_MHZ    = 12,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_BITS  = 8,
  parameter int DIV_BITS   = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus,
  output logic           tx,
  output logic           ready
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [DIV_BITS-1:0] DEFAULT_DIV = DIV_BITS'(CLK_MHZ * 1000000 / BAUD);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // FIFO
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       level;
  logic                 full, empty, push, pop;

  // Control register and read response
  logic [DIV_BITS-1:0]  div_q, div_d;
  logic                 stop2_q, stop2_d, par_en_q, par_en_d, par_odd_q, par_odd_d;
  logic                 rvalid_q, rvalid_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [31:0]          ctrl_rd, ctrl_mask, ctrl_new;
  logic                 unused_ctrl;

  // Transmitter; f_* hold the configuration latched for the current frame
  logic [2:0]           state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DIV_BITS-1:0]  baud_q, baud_d, f_div_q, f_div_d, reload_cnt;
  logic                 f_stop2_q, f_stop2_d, f_par_en_q, f_par_en_d, f_par_odd_q, f_par_odd_d;
  logic                 parity_q, parity_d, tx_q, tx_d;
  logic                 bit_done, frame_end, busy;

  assign full  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {PTR_W{1'b0}}};
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign level = wr_ptr_q - rd_ptr_q;
  assign busy  = (state_q != S_IDLE);

  // A full FIFO holds off a TXDATA write rather than dropping it.
  assign bus.gnt    = bus.req & ~(bus.we & (bus.addr == 2'd0) & full);
  assign push       = bus.req & bus.we & (bus.addr == 2'd0) & bus.be[0] & ~full;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign tx         = tx_q;
  assign ready      = ~full;

  assign ctrl_rd     = 32'(div_q) | {13'b0, par_odd_q, par_en_q, stop2_q, 16'b0};
  assign ctrl_mask   = {{8{bus.be[3]}}, {8{bus.be[2]}}, {8{bus.be[1]}}, {8{bus.be[0]}}};
  assign ctrl_new    = (ctrl_rd & ~ctrl_mask) | (bus.wdata & ctrl_mask);
  assign unused_ctrl = ^ctrl_new;

  // div = 0 behaves as one cycle per bit.
  assign reload_cnt = (f_div_q == '0) ? '0 : f_div_q - 1'b1;

  // Pointer advance, CTRL update and registered read response.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    wr_ptr_d  = wr_ptr_q + (PTR_W + 1)'(push);
    rd_ptr_d  = rd_ptr_q + (PTR_W + 1)'(pop);
    div_d     = div_q;
    stop2_d   = stop2_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    rvalid_d  = 1'b0;
    rdata_d   = '0;
    if (bus.req && bus.we && bus.addr == 2'd2) begin
      div_d     = ctrl_new[DIV_BITS-1:0];
      stop2_d   = ctrl_new[16];
      par_en_d  = ctrl_new[17];
      par_odd_d = ctrl_new[18];
    end
    if (bus.req && !bus.we) begin
      rvalid_d = 1'b1;
      case (bus.addr)
        2'd1:    rdata_d = {24'(level), 4'b0, full, empty, busy, ~full};
        2'd2:    rdata_d = ctrl_rd;
        default: rdata_d = '0;
      endcase
    end
  end

  // Frame sequencing; a new frame loads from IDLE or straight out of the last stop cycle.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    baud_d      = baud_q;
    f_div_d     = f_div_q;
    f_stop2_d   = f_stop2_q;
    f_par_en_d  = f_par_en_q;
    f_par_odd_d = f_par_odd_q;
    parity_d    = parity_q;
    pop         = 1'b0;
    frame_end   = 1'b0;
    bit_done    = (baud_q == '0);
    if (state_q != S_IDLE && !bit_done) baud_d = baud_q - 1'b1;
    case (state_q)
      S_IDLE: ;
      S_START: if (bit_done) begin
        state_d   = S_DATA;
        baud_d    = reload_cnt;
        bit_cnt_d = '0;
      end
      S_DATA: if (bit_done) begin
        baud_d = reload_cnt;
        if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
          state_d   = f_par_en_q ? S_PARITY : S_STOP;
          bit_cnt_d = '0;
        end else begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_PARITY: if (bit_done) begin
        state_d = S_STOP;
        baud_d  = reload_cnt;
      end
      S_STOP: if (bit_done) begin
        if (f_stop2_q && bit_cnt_q == '0) begin
          bit_cnt_d = CNT_W'(1);
          baud_d    = reload_cnt;
        end else begin
          state_d   = S_IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_q == S_IDLE || frame_end) && !empty) begin
      pop         = 1'b1;
      state_d     = S_START;
      shift_d     = mem_q[rd_ptr_q[PTR_W-1:0]];
      parity_d    = (^mem_q[rd_ptr_q[PTR_W-1:0]]) ^ par_odd_q;
      f_div_d     = div_q;
      f_stop2_d   = stop2_q;
      f_par_en_d  = par_en_q;
      f_par_odd_d = par_odd_q;
      baud_d      = (div_q == '0) ? '0 : div_q - 1'b1;
    end
  end

  // Serial line level for the state being entered, so tx is a clean register output.
  always_comb begin
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= bus.wdata[DATA_BITS-1:0];
  end

  // State registers; reset drives tx high at once and empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      div_q       <= DEFAULT_DIV;
      stop2_q     <= 1'b0;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      baud_q      <= '0;
      f_div_q     <= DEFAULT_DIV;
      f_stop2_q   <= 1'b0;
      f_par_en_q  <= 1'b0;
      f_par_odd_q <= 1'b0;
      parity_q    <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      div_q       <= div_d;
      stop2_q     <= stop2_d;
      par_en_q    <= par_en_d;
      par_odd_q   <= par_odd_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      baud_q      <= baud_d;
      f_div_q     <= f_div_d;
      f_stop2_q   <= f_stop2_d;
      f_par_en_q  <= f_par_en_d;
      f_par_odd_q <= f_par_odd_d;
      parity_q    <= parity_d;
      tx_q        <= tx_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue/waveform model checked every
// cycle, plus hand-computed literal expectations for each directed scenario.
module tb_uart_tx_fifo;
  localparam int DEPTH = 8;
  localparam int DB    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx, ready;
  int   checks   = 0;
  int   failures = 0;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(
    .CLK_MHZ(12), .BAUD(115200), .FIFO_DEPTH(DEPTH), .DATA_BITS(DB), .DIV_BITS(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .tx(tx), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit   [7:0]  m_q[$];        // FIFO contents, head first
  bit          m_wave[$];     // expected tx level per cycle of the frame in flight
  logic [15:0] m_div     = 16'd104;
  bit          m_stop2   = 1'b0;
  bit          m_par_en  = 1'b0;
  bit          m_par_odd = 1'b0;
  bit          m_rv      = 1'b0;
  logic [31:0] m_rdata   = '0;
  bit          m_acc     = 1'b0;

  // Expand one byte into its per-cycle line levels.
  task automatic build_frame(input bit [7:0] d);
    int bt = (m_div == 16'd0) ? 1 : int'(m_div);
    bit seq[$];
    seq.push_back(1'b0);
    for (int i = 0; i < DB; i++) seq.push_back(d[i]);
    if (m_par_en) seq.push_back((^d) ^ m_par_odd);
    seq.push_back(1'b1);
    if (m_stop2) seq.push_back(1'b1);
    foreach (seq[i]) repeat (bt) m_wave.push_back(seq[i]);
  endtask

  initial begin : model_proc
    bit          full_pre, busy_pre;
    int          lvl;
    logic [31:0] ctrl_w, mask;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete();
        m_wave.delete();
        m_div = 16'd104; m_stop2 = 1'b0; m_par_en = 1'b0; m_par_odd = 1'b0;
        m_rv = 1'b0; m_rdata = '0; m_acc = 1'b0;
      end else begin
        lvl      = m_q.size();
        full_pre = (lvl == DEPTH);
        busy_pre = (m_wave.size() != 0);
        ctrl_w   = {13'b0, m_par_odd, m_par_en, m_stop2, m_div};
        m_acc    = bus.req && !(bus.we && bus.addr == 2'd0 && full_pre);
        m_rv     = bus.req && !bus.we;
        m_rdata  = '0;
        if (m_rv && bus.addr == 2'd1)
          m_rdata = {24'(lvl), 4'b0, full_pre, lvl == 0, busy_pre, !full_pre};
        if (m_rv && bus.addr == 2'd2) m_rdata = ctrl_w;
        if (busy_pre) void'(m_wave.pop_front());
        if (m_wave.size() == 0 && lvl != 0) build_frame(m_q.pop_front());
        if (m_acc && bus.we) begin
          if (bus.addr == 2'd0 && bus.be[0]) m_q.push_back(bus.wdata[7:0]);
          if (bus.addr == 2'd2) begin
            mask      = {{8{bus.be[3]}}, {8{bus.be[2]}}, {8{bus.be[1]}}, {8{bus.be[0]}}};
            ctrl_w    = (ctrl_w & ~mask) | (bus.wdata & mask);
            m_div     = ctrl_w[15:0];
            m_stop2   = ctrl_w[16];
            m_par_en  = ctrl_w[17];
            m_par_odd = ctrl_w[18];
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin : compare_proc
    @(negedge rst);
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        check("tx", tx, (m_wave.size() != 0) ? m_wave[0] : 1'b1);
        check("ready", ready, m_q.size() != DEPTH);
        check("gnt", bus.gnt, bus.req && !(bus.we && bus.addr == 2'd0 && m_q.size() == DEPTH));
        check("rvalid", bus.rvalid, m_rv);
        check("rdata", bus.rdata, m_rdata);
      end
    end
  end

  // ---------------- bus driver ----------------
  task automatic bus_idle();
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = '0; bus.be = 4'h0;
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus_idle();
  endtask

  // Holds the request until accepted; returns the number of stalled cycles.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b,
                           output int stalls);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d; bus.be = b;
    stalls = 0;
    forever begin
      @(posedge clk);
      #1;
      if (m_acc) break;
      stalls++;
      if (stalls > 500) begin
        checks++; failures++;
        $display("FAIL write_grant_timeout: actual=no grant required=grant within 500 cycles");
        break;
      end
    end
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = a; bus.wdata = '0; bus.be = 4'h0;
    @(posedge clk);
    #1;
    d = bus.rdata;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  initial begin : stim
    logic [31:0] rd;
    logic [39:0] w40;
    logic [23:0] w24;
    logic [59:0] w60;
    int          st, total_st, zeros;

    bus_idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_ready", ready, 1'b1);
    check("rst_rvalid", bus.rvalid, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Reset state and register map corners
    bus_read(2'd1, rd); check("reset_status", rd, 32'h0000_0005);
    bus_read(2'd2, rd); check("reset_ctrl", rd, 32'd104);
    bus_read(2'd3, rd); check("addr3_read", rd, 32'h0);
    bus_write(2'd0, 32'h77, 4'hE, st);
    bus_read(2'd1, rd); check("be0_low_no_push", rd, 32'h0000_0005);

    // Basic frame: div 4, 0x55
    bus_write(2'd2, 32'h4, 4'hF, st);
    bus_write(2'd0, 32'h55, 4'h1, st);
    go_idle();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1; w40[39-i] = tx;
    end
    check("basic_wave", w40, 40'h0F0F0F0F0F);
    repeat (2) @(posedge clk);
    bus_read(2'd1, rd); check("basic_idle_status", rd, 32'h0000_0005);

    // Odd parity, two stop bits, div 2, 0x03
    bus_write(2'd2, 32'h0007_0002, 4'hF, st);
    bus_write(2'd0, 32'h03, 4'h1, st);
    go_idle();
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1; w24[23-i] = tx;
    end
    check("parity_wave", w24, 24'h3C003F);
    repeat (2) @(posedge clk);
    bus_read(2'd2, rd); check("ctrl_readback", rd, 32'h0007_0002);

    // Back-pressure: div 1, ten back-to-back writes
    bus_write(2'd2, 32'h1, 4'hF, st);
    total_st = 0;
    for (int i = 0; i < 10; i++) begin
      bus_write(2'd0, 32'hA0 + i, 4'h1, st);
      total_st += st;
    end
    check("bp_stall_cycles", total_st, 3);
    go_idle();
    repeat (110) @(posedge clk);
    bus_read(2'd1, rd); check("bp_drained_status", rd, 32'h0000_0005);

    // Divisor change mid-frame applies to the next frame only
    bus_write(2'd2, 32'h4, 4'hF, st);
    bus_write(2'd0, 32'h0F, 4'h1, st);
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          @(posedge clk); #1; w60[59-i] = tx;
        end
      end
      begin
        bus_write(2'd0, 32'hF0, 4'h1, st);
        bus_write(2'd2, 32'h2, 4'hF, st);
        go_idle();
      end
    join
    check("cfg_change_wave", w60, 60'h0FFFF0000F003FF);
    repeat (4) @(posedge clk);

    // Asynchronous reset mid-DATA with three entries queued
    bus_write(2'd2, 32'h4, 4'hF, st);
    bus_write(2'd0, 32'h00, 4'h1, st);
    bus_write(2'd0, 32'h11, 4'h1, st);
    bus_write(2'd0, 32'h22, 4'h1, st);
    bus_write(2'd0, 32'h33, 4'h1, st);
    go_idle();
    repeat (7) @(posedge clk);
    #3;
    check("pre_reset_tx", tx, 1'b0);
    rst = 1'b1;
    #1;
    check("async_reset_tx", tx, 1'b1);
    check("async_reset_ready", ready, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus_read(2'd1, rd); check("post_reset_status", rd, 32'h0000_0005);
    bus_read(2'd2, rd); check("post_reset_ctrl", rd, 32'd104);
    go_idle();
    zeros = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) zeros++;
    end
    check("post_reset_quiet", zeros, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
